sram_model: RTL and testbench

SRAM_MODEL -- requirements
Module: sram_model

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_read_pipe.sv | 46 ++++
 rtl/sram_model.sv | 108 ++++++++++
 tb/tb_sram_model.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the behavioural SRAM model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_pkg;

    // Width of the controller-side address bus; upper bits beyond ADDR_W alias.
    localparam int SRAM_ADDR_W  = 18;

    // Default geometry of the modelled device.
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_DATA_W   = 16;

    // Supported read-latency range of the data return pipeline.
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    // INIT runs the post-reset clear sweep; READY services the controller.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/sram_read_pipe.sv
// Valid+data delay line carrying read results towards the DQ bus.
// Latency: DEPTH clocks from i_vld/i_dat to o_vld/o_dat.
// Backpressure: none; shifts every clock, rst synchronously drops all valids.
module sram_read_pipe
    import sram_pkg::*;
#(
    parameter int DEPTH  = READ_LAT_MIN,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat
);

    logic              r_vld [DEPTH];
    logic [DATA_W-1:0] r_dat [DEPTH];

    // Valid chain: shifts every clock, cleared by reset so the bus is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Data chain: no reset needed, contents only matter when the valid is set.
    always_ff @(posedge clk) begin
        r_dat[0] <= i_dat;
        for (int i = 1; i < DEPTH; i++) begin
            r_dat[i] <= r_dat[i-1];
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_dat = r_dat[DEPTH-1];

endmodule

// File: rtl/sram_model.sv
// Behavioural synchronous SRAM with optional post-reset clear sweep and write counter.
// Latency: read data on SRAM_DQ READ_LAT clocks after the read address is sampled.
// Backpressure: none; the controller owns bus timing, the model only drives DQ on read cycles.
module sram_model
    import sram_pkg::*;
#(
    parameter int               ADDR_W         = DEF_ADDR_W,
    parameter int               DATA_W         = DEF_DATA_W,
    parameter int               READ_LAT       = 1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    input  logic                   SRAM_WE_N,
    inout  wire  [DATA_W-1:0]      SRAM_DQ,
    output logic                   init_busy,
    output logic [31:0]            wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    // Out-of-range latencies are pulled into the supported window.
    localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                         (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_init_busy;
    logic [31:0]       r_wr_count;

    logic [ADDR_W-1:0] w_addr;
    logic              w_clr_wr;
    logic              w_host_wr;
    logic              w_host_rd;
    logic [DATA_W-1:0] w_rd_dat;
    logic              w_tail_vld;
    logic [DATA_W-1:0] w_tail_dat;
    logic              w_unused_addr;

    // Upper address bits are ignored so addresses alias modulo the depth.
    assign w_addr        = SRAM_ADDR[ADDR_W-1:0];
    assign w_unused_addr = ^SRAM_ADDR;

    // Reset beats any same-cycle write; the controller is ignored during the sweep.
    assign w_clr_wr  = !rst && (r_state == INIT);
    assign w_host_wr = !rst && (r_state == READY) && !SRAM_WE_N;
    assign w_host_rd = !rst && (r_state == READY) &&  SRAM_WE_N;

    // Array read sees all writes committed on earlier edges.
    assign w_rd_dat = r_mem[w_addr];

    // Sweep sequencer: INIT walks every address once, then hands over to READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLEAR_ON_RESET ? INIT : READY;
            r_clr_ptr   <= '0;
            r_init_busy <= CLEAR_ON_RESET;
        end else if (r_state == INIT) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            if (r_clr_ptr == LAST_ADDR) begin
                r_state     <= READY;
                r_init_busy <= 1'b0;
            end
        end
    end

    // Storage update: no reset so contents survive reset when the sweep is disabled.
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_ptr] <= INIT_VALUE;
        end else if (w_host_wr) begin
            r_mem[w_addr] <= SRAM_DQ;
        end
    end

    // Accepted-write counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_host_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    sram_read_pipe #(
        .DEPTH  (LAT),
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_host_rd),
        .i_dat (w_rd_dat),
        .o_vld (w_tail_vld),
        .o_dat (w_tail_dat)
    );

    // Drive only on a valid tail during a read cycle so a controller write never sees contention.
    assign SRAM_DQ = (w_tail_vld && SRAM_WE_N) ? w_tail_dat : {DATA_W{1'bz}};

    assign init_busy = r_init_busy;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_sram_model.sv
// Bench for sram_model: two instances (READ_LAT=1 with clear sweep, READ_LAT=3 without).
// Stimulus pushes expected read words tagged with their due cycle; a negedge monitor pops and compares.
// The DQ nets are pulled up, so a released bus reads 16'hFFFF; test data never uses that word.
module tb_sram_model;

    localparam int          AW   = 4;
    localparam int          L0   = 1;
    localparam int          L1   = 3;
    localparam logic [15:0] IDLE = 16'hFFFF;

    typedef struct {
        logic [15:0] dat;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    logic        rst0 = 1'b1, we_n0 = 1'b1, tb_en0 = 1'b0, busy0;
    logic [17:0] addr0 = '0;
    logic [15:0] tb_dat0 = '0;
    logic [31:0] cnt0;
    tri1  [15:0] dq0;
    bit          rdy0 = 1'b0;
    exp_t        sb0[$];

    logic        rst1 = 1'b1, we_n1 = 1'b1, tb_en1 = 1'b0, busy1;
    logic [17:0] addr1 = '0;
    logic [15:0] tb_dat1 = '0;
    logic [31:0] cnt1;
    tri1  [15:0] dq1;
    bit          rdy1 = 1'b0;
    exp_t        sb1[$];

    assign dq0 = tb_en0 ? tb_dat0 : 16'hzzzz;
    assign dq1 = tb_en1 ? tb_dat1 : 16'hzzzz;

    sram_model #(
        .ADDR_W(AW), .DATA_W(16), .READ_LAT(L0), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0000)
    ) u_dut0 (
        .clk(clk), .rst(rst0), .SRAM_ADDR(addr0), .SRAM_WE_N(we_n0),
        .SRAM_DQ(dq0), .init_busy(busy0), .wr_count(cnt0)
    );

    sram_model #(
        .ADDR_W(AW), .DATA_W(16), .READ_LAT(L1), .CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0000)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1),
        .SRAM_DQ(dq1), .init_busy(busy1), .wr_count(cnt1)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void bus_chk(string name, logic [15:0] dq, bit drv, logic [15:0] e);
        n_checks++;
        if (drv && (dq !== e)) begin
            n_errors++;
            $display("FAIL %s read data at cycle %0d: got %h want %h", name, cyc, dq, e);
        end else if (!drv && (dq !== IDLE)) begin
            n_errors++;
            $display("FAIL %s bus release at cycle %0d: got %h want %h (undriven)", name, cyc, dq, IDLE);
        end
    endfunction

    // Monitor for instance 0
    always @(negedge clk) begin
        if (mon_en) begin
            bit          due;
            logic [15:0] e;
            due = 1'b0;
            e   = '0;
            while (sb0.size() > 0 && sb0[0].due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL dq0 lost read: word %h due cycle %0d not seen", sb0[0].dat, sb0[0].due);
                void'(sb0.pop_front());
            end
            if (sb0.size() > 0 && sb0[0].due == cyc) begin
                due = 1'b1;
                e   = sb0[0].dat;
                void'(sb0.pop_front());
            end
            if (!tb_en0) bus_chk("dq0", dq0, due && we_n0, e);
        end
    end

    // Monitor for instance 1
    always @(negedge clk) begin
        if (mon_en) begin
            bit          due;
            logic [15:0] e;
            due = 1'b0;
            e   = '0;
            while (sb1.size() > 0 && sb1[0].due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL dq1 lost read: word %h due cycle %0d not seen", sb1[0].dat, sb1[0].due);
                void'(sb1.pop_front());
            end
            if (sb1.size() > 0 && sb1[0].due == cyc) begin
                due = 1'b1;
                e   = sb1[0].dat;
                void'(sb1.pop_front());
            end
            if (!tb_en1) bus_chk("dq1", dq1, due && we_n1, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle on instance 0; for reads d is the expected word.
    task automatic op0(input bit r, input bit we_n, input logic [17:0] a,
                       input logic [15:0] d, input bit drive);
        exp_t x;
        rst0    = r;
        we_n0   = we_n;
        addr0   = a;
        tb_dat0 = d;
        tb_en0  = !we_n && drive;
        if (r) begin
            while (sb0.size() > 0 && sb0[$].due > cyc) void'(sb0.pop_back());
        end else if (we_n && rdy0) begin
            x.dat = d;
            x.due = cyc + L0;
            sb0.push_back(x);
        end
        tick();
    endtask

    // One bus cycle on instance 1; for reads d is the expected word.
    task automatic op1(input bit r, input bit we_n, input logic [17:0] a,
                       input logic [15:0] d, input bit drive);
        exp_t x;
        rst1    = r;
        we_n1   = we_n;
        addr1   = a;
        tb_dat1 = d;
        tb_en1  = !we_n && drive;
        if (r) begin
            while (sb1.size() > 0 && sb1[$].due > cyc) void'(sb1.pop_back());
        end else if (we_n && rdy1) begin
            x.dat = d;
            x.due = cyc + L1;
            sb1.push_back(x);
        end
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        mon_en = 1'b1;

        chk("busy0_reset", 32'(busy0), 32'd1);
        chk("cnt0_reset",  cnt0,       32'd0);
        chk("busy1_reset", 32'(busy1), 32'd0);
        chk("cnt1_reset",  cnt1,       32'd0);

        // Clear sweep with a write attempt held throughout; it must be ignored.
        rst0 = 1'b0; we_n0 = 1'b0; addr0 = 18'd3; tb_dat0 = 16'h5A5A; tb_en0 = 1'b1;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
        chk("sweep0_len", 32'(n), 32'd16);
        chk("cnt0_after_sweep", cnt0, 32'd0);
        rdy0 = 1'b1;

        // Every address reads back the clear value.
        for (int a = 0; a < 16; a++) op0(1'b0, 1'b1, 18'(a), 16'h0000, 1'b0);

        // Write then immediate read-back.
        op0(1'b0, 1'b0, 18'd5, 16'hBEEF, 1'b1);
        op0(1'b0, 1'b1, 18'd5, 16'hBEEF, 1'b0);
        chk("cnt0_one_write", cnt0, 32'd1);

        // Aliasing through the upper address bits.
        op0(1'b0, 1'b0, 18'h3FFF7, 16'hC3C3, 1'b1);
        op0(1'b0, 1'b1, 18'd7,     16'hC3C3, 1'b0);
        op0(1'b0, 1'b1, 18'h20017, 16'hC3C3, 1'b0);

        // Read in flight, then a write cycle with the bus left floating: model must not drive.
        op0(1'b0, 1'b1, 18'd5, 16'hBEEF, 1'b0);
        op0(1'b0, 1'b0, 18'd9, 16'h0000, 1'b0);
        op0(1'b0, 1'b1, 18'd5, 16'hBEEF, 1'b0);
        chk("cnt0_three_writes", cnt0, 32'd3);

        // Reset mid-sweep at pointer 7 together with a write.
        op0(1'b1, 1'b1, 18'd0, 16'h0000, 1'b0);
        rdy0 = 1'b0;
        chk("busy0_rerun", 32'(busy0), 32'd1);
        repeat (7) op0(1'b0, 1'b1, 18'd0, 16'h0000, 1'b0);
        op0(1'b1, 1'b0, 18'd7, 16'hABCD, 1'b1);
        chk("busy0_restart", 32'(busy0), 32'd1);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            op0(1'b0, 1'b1, 18'd0, 16'h0000, 1'b0);
        end
        chk("sweep0_restart_len", 32'(n), 32'd16);
        chk("cnt0_after_restart", cnt0, 32'd0);
        rdy0 = 1'b1;
        op0(1'b0, 1'b1, 18'd7, 16'h0000, 1'b0);
        op0(1'b1, 1'b1, 18'd0, 16'h0000, 1'b0);
        rdy0 = 1'b0;

        // Instance 1: no sweep, READ_LAT=3.
        rdy1 = 1'b1;
        op1(1'b0, 1'b0, 18'd1, 16'h0011, 1'b1);
        op1(1'b0, 1'b0, 18'd2, 16'h0022, 1'b1);
        op1(1'b0, 1'b0, 18'd3, 16'h0033, 1'b1);
        chk("busy1_ready", 32'(busy1), 32'd0);
        chk("cnt1_preload", cnt1, 32'd3);
        op1(1'b0, 1'b1, 18'd1, 16'h0011, 1'b0);
        op1(1'b0, 1'b1, 18'd2, 16'h0022, 1'b0);
        op1(1'b0, 1'b1, 18'd3, 16'h0033, 1'b0);
        op1(1'b0, 1'b1, 18'd1, 16'h0011, 1'b0);
        op1(1'b0, 1'b1, 18'd2, 16'h0022, 1'b0);
        op1(1'b0, 1'b1, 18'd3, 16'h0033, 1'b0);

        // Pipeline full, then floating write cycles: bus stays released throughout.
        op1(1'b0, 1'b0, 18'd9,  16'h0000, 1'b0);
        op1(1'b0, 1'b0, 18'd10, 16'h0000, 1'b0);
        op1(1'b0, 1'b0, 18'd11, 16'h0000, 1'b0);
        op1(1'b0, 1'b1, 18'd3, 16'h0033, 1'b0);
        op1(1'b0, 1'b1, 18'd2, 16'h0022, 1'b0);
        op1(1'b0, 1'b1, 18'd1, 16'h0011, 1'b0);
        chk("cnt1_six_writes", cnt1, 32'd6);

        // Aliased write, then reset colliding with a write: contents survive, write is dropped.
        op1(1'b0, 1'b0, 18'h12, 16'h1234, 1'b1);
        op1(1'b1, 1'b0, 18'd2,  16'h5555, 1'b1);
        chk("cnt1_after_reset", cnt1, 32'd0);
        chk("busy1_after_reset", 32'(busy1), 32'd0);
        op1(1'b0, 1'b1, 18'd2,  16'h1234, 1'b0);
        op1(1'b0, 1'b1, 18'h12, 16'h1234, 1'b0);
        op1(1'b0, 1'b1, 18'd1,  16'h0011, 1'b0);
        op1(1'b0, 1'b1, 18'd3,  16'h0033, 1'b0);
        op1(1'b0, 1'b1, 18'd3,  16'h0033, 1'b0);
        op1(1'b0, 1'b1, 18'd3,  16'h0033, 1'b0);
        op1(1'b1, 1'b1, 18'd0,  16'h0000, 1'b0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
